id_operand_stage: RTL and testbench
===================================

// Module: id_operand_stage
// PURPOSE
//  Parametrised decode-stage operand unit: holds the IF->ID pipeline register, reads the
//  register file and selects operands through an N-source forwarding network with
//  per-source readiness. Producers whose result is not yet available (e.g. a load in EX
//  or MEM) raise an interlock. Sits between the fetch and execute stages of the 5-stage
//  MIPS pipeline, with flush support and a saturating stall-cycle counter.
// PARAMETERS
//  DW       32  operand/data width
//  RA_W     5   register address width (register 0 is hardwired zero, never forwarded)
//  NUM_FWD  3   forwarding sources; index 0 = youngest (EX), highest priority
//  IN_W     64  opaque payload width ({inst,pc}), passed through unchanged
//  CNT_W    16  stall counter width
// PORTS
//  clk          in   1             clock
//  reset        in   1             synchronous, active-high reset
//  in_valid     in   1             upstream instruction valid
//  in_allowin   out  1             stage can accept: !ds_valid | (ready_go & out_allowin)
//  in_bus       in   IN_W          payload, captured with in_rs/in_rt/in_use_*
//  in_rs,in_rt  in   RA_W each     source register numbers
//  in_use_rs    in   1             instruction reads rs (else no rs hazard)
//  in_use_rt    in   1             instruction reads rt (else no rt hazard)
//  flush        in   1             discard held instruction (branch/exception)
//  out_valid    out  1             ds_valid & ready_go & !flush
//  out_allowin  in   1             downstream can accept
//  out_bus      out  IN_W          registered payload
//  out_rs_val   out  DW            forwarded rs operand
//  out_rt_val   out  DW            forwarded rt operand
//  rf_raddr1/2  out  RA_W each     register-file read addresses (= held rs/rt)
//  rf_rdata1/2  in   DW each       combinational register-file read data
//  fwd_valid    in   NUM_FWD       source i holds a valid register-writing instruction
//  fwd_dest     in   NUM_FWD*RA_W  destination of source i (slice i)
//  fwd_ready    in   NUM_FWD       source i data is final this cycle
//  fwd_data     in   NUM_FWD*DW    result of source i
//  stall_cnt    out  CNT_W         cycles spent with ds_valid & !ready_go (saturating)
// BEHAVIOUR
//  - Reset: ds_valid=0, held rs/rt/use/payload=0, stall_cnt=0, hence out_valid=0.
//  - Capture: if in_valid & in_allowin, latch bus/rs/rt/use flags at the edge; ds_valid <=
//    in_valid whenever in_allowin. Zero-bubble throughput: 1 instr/cycle with no hazards.
//  - Match i for operand r: use_r & r!=0 & fwd_valid[i] & fwd_dest[i]==r.
//  - Selection: lowest matching i wins; no match -> rf_rdata. Combinational, same cycle.
//  - Interlock: the operand is blocked if its winning source has fwd_ready=0. Older
//    matching sources are never used in place of a blocked younger one.
//    ready_go = !(rs_blocked | rt_blocked).
//  - rs==rt: both operands resolve identically; a single block stalls the instruction.
//  - Stall: while !ready_go, the held instruction is kept, in_allowin=0 and operands are
//    re-evaluated every cycle; issue occurs in the first cycle the source becomes ready.
//  - out_allowin=0 with ready_go=1: hold the instruction, in_allowin=0, no stall count.
//  - flush: at the next edge ds_valid<=0 and out_valid is forced to 0 this cycle. If
//    in_valid & in_allowin in the same cycle, the incoming instruction is also dropped.
//  - stall_cnt: +1 per cycle with ds_valid & !ready_go & !flush. Holds at 2^CNT_W-1.
//  - Reset mid-stall clears ds_valid and the counter. No partial issue is observable.
// STRUCTURE
//  - Shared header (mycpu.h): `DS_DW, `DS_RA_W, `DS_NUM_FWD defaults, FWD_EX/MEM/WB
//    index constants, and macros slicing fwd_dest/fwd_data.
//  - Sub-module id_fwd_select (one instance per operand). Inputs: reg number, use flag,
//    fwd vectors and rf data. Outputs: value and blocked. Purely combinational priority
//    loop over NUM_FWD. The top level holds the pipeline register, handshake, flush and
//    counter.
// TESTING
//  1 No hazard: 4 back-to-back addu, out_allowin=1 -> out_valid every cycle, rf values
//    pass through, stall_cnt=0.
//  2 Priority: rs=5, src0 dest5 data 0x11, src2 dest5 data 0x33, both ready ->
//    out_rs_val=0x11. Drop src0 -> 0x33.
//  3 Load-use: rt=7, src0 dest7 ready=0 for 2 cycles then ready data 0xCAFE -> out_valid
//    low for 2 cycles, issue with out_rt_val=0xCAFE, stall_cnt=2, in_allowin low
//    throughout.
//  4 Zero/unused: rs=0 with src0 dest0 ready=0 -> no stall, out_rs_val=0.
//    in_use_rt=0 with matching unready src -> no stall.
//  5 Flush during stall: stalled instruction plus flush -> out_valid=0, next cycle
//    ds_valid=0, new instruction accepted.
//  6 Backpressure and saturation: CNT_W=2 with 5 stall cycles -> stall_cnt=3. out_allowin=0
//    -> out_bus stable, in_allowin=0. Reset mid-stall -> all outputs return to 0.

Source files
------------

// File: rtl/id_operand_stage_pkg.sv
// Shared constants for the decode-stage operand unit: default widths,
// forwarding-source indices and a helper for slicing packed per-source vectors.
package id_operand_stage_pkg;

  localparam int DS_DW      = 32;
  localparam int DS_RA_W    = 5;
  localparam int DS_NUM_FWD = 3;
  localparam int DS_IN_W    = 64;
  localparam int DS_CNT_W   = 16;

  // Forwarding source order: lower index = younger producer = higher priority.
  typedef enum int {
    FWD_EX  = 0,
    FWD_MEM = 1,
    FWD_WB  = 2
  } fwd_src_e;

  // LSB of slice idx inside a packed vector of w-bit fields.
  function automatic int fwd_lsb(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/id_operand_stage_fwd_select.sv
// Operand forwarding selector: picks the youngest source writing the requested
// register, falls back to register-file data, and reports whether the winning
// source has not produced its final value yet.
module id_fwd_select
  import id_operand_stage_pkg::*;
#(
  parameter int DW      = DS_DW,
  parameter int RA_W    = DS_RA_W,
  parameter int NUM_FWD = DS_NUM_FWD
) (
  input  logic [RA_W-1:0]         reg_num,
  input  logic                    use_reg,
  input  logic [NUM_FWD-1:0]      fwd_valid,
  input  logic [NUM_FWD*RA_W-1:0] fwd_dest,
  input  logic [NUM_FWD-1:0]      fwd_ready,
  input  logic [NUM_FWD*DW-1:0]   fwd_data,
  input  logic [DW-1:0]           rf_data,
  output logic [DW-1:0]           value,
  output logic                    blocked
);

  logic [NUM_FWD-1:0] match;
  logic [DW-1:0]      src_data [NUM_FWD];
  logic               found;

  // Register 0 never matches: it is constant zero and must come from the file.
  generate
    for (genvar gi = 0; gi < NUM_FWD; gi++) begin : g_src
      assign match[gi] = use_reg && (reg_num != '0) && fwd_valid[gi] &&
                         (fwd_dest[fwd_lsb(gi, RA_W) +: RA_W] == reg_num);
      assign src_data[gi] = fwd_data[fwd_lsb(gi, DW) +: DW];
    end
  endgenerate

  // Priority pick: first matching source wins, and its readiness alone decides
  // blocking, so an older source can never stand in for a blocked younger one.
  always_comb begin
    value   = rf_data;
    blocked = 1'b0;
    found   = 1'b0;
    for (int i = 0; i < NUM_FWD; i++) begin
      if (match[i] && !found) begin
        found   = 1'b1;
        value   = src_data[i];
        blocked = !fwd_ready[i];
      end
    end
  end

endmodule

// File: rtl/id_operand_stage.sv
// Decode-stage operand unit: IF->ID pipeline register with valid/allowin
// handshake, flush, forwarding-based operand selection with interlock, and a
// saturating counter of interlock cycles.
module id_operand_stage
  import id_operand_stage_pkg::*;
#(
  parameter int DW      = DS_DW,
  parameter int RA_W    = DS_RA_W,
  parameter int NUM_FWD = DS_NUM_FWD,
  parameter int IN_W    = DS_IN_W,
  parameter int CNT_W   = DS_CNT_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_allowin,
  input  logic [IN_W-1:0]         in_bus,
  input  logic [RA_W-1:0]         in_rs,
  input  logic [RA_W-1:0]         in_rt,
  input  logic                    in_use_rs,
  input  logic                    in_use_rt,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_allowin,
  output logic [IN_W-1:0]         out_bus,
  output logic [DW-1:0]           out_rs_val,
  output logic [DW-1:0]           out_rt_val,
  output logic [RA_W-1:0]         rf_raddr1,
  output logic [RA_W-1:0]         rf_raddr2,
  input  logic [DW-1:0]           rf_rdata1,
  input  logic [DW-1:0]           rf_rdata2,
  input  logic [NUM_FWD-1:0]      fwd_valid,
  input  logic [NUM_FWD*RA_W-1:0] fwd_dest,
  input  logic [NUM_FWD-1:0]      fwd_ready,
  input  logic [NUM_FWD*DW-1:0]   fwd_data,
  output logic [CNT_W-1:0]        stall_cnt
);

  logic              ds_valid_q, ds_valid_d;
  logic [RA_W-1:0]   rs_q, rs_d;
  logic [RA_W-1:0]   rt_q, rt_d;
  logic              use_rs_q, use_rs_d;
  logic              use_rt_q, use_rt_d;
  logic [IN_W-1:0]   bus_q, bus_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic              rs_blocked, rt_blocked;
  logic              ready_go;

  id_fwd_select #(.DW(DW), .RA_W(RA_W), .NUM_FWD(NUM_FWD)) u_rs_sel (
    .reg_num   (rs_q),
    .use_reg   (use_rs_q),
    .fwd_valid (fwd_valid),
    .fwd_dest  (fwd_dest),
    .fwd_ready (fwd_ready),
    .fwd_data  (fwd_data),
    .rf_data   (rf_rdata1),
    .value     (out_rs_val),
    .blocked   (rs_blocked)
  );

  id_fwd_select #(.DW(DW), .RA_W(RA_W), .NUM_FWD(NUM_FWD)) u_rt_sel (
    .reg_num   (rt_q),
    .use_reg   (use_rt_q),
    .fwd_valid (fwd_valid),
    .fwd_dest  (fwd_dest),
    .fwd_ready (fwd_ready),
    .fwd_data  (fwd_data),
    .rf_data   (rf_rdata2),
    .value     (out_rt_val),
    .blocked   (rt_blocked)
  );

  // Handshake: the held instruction leaves only when both operands are final and
  // downstream accepts; flush suppresses issue in the current cycle.
  always_comb begin
    ready_go   = !(rs_blocked || rt_blocked);
    in_allowin = !ds_valid_q || (ready_go && out_allowin);
    out_valid  = ds_valid_q && ready_go && !flush;
    out_bus    = bus_q;
    rf_raddr1  = rs_q;
    rf_raddr2  = rt_q;
    stall_cnt  = stall_cnt_q;
  end

  // Next-state: capture on accept, drop on flush, count interlock cycles.
  always_comb begin
    ds_valid_d  = ds_valid_q;
    rs_d        = rs_q;
    rt_d        = rt_q;
    use_rs_d    = use_rs_q;
    use_rt_d    = use_rt_q;
    bus_d       = bus_q;
    stall_cnt_d = stall_cnt_q;

    if (in_valid && in_allowin) begin
      rs_d     = in_rs;
      rt_d     = in_rt;
      use_rs_d = in_use_rs;
      use_rt_d = in_use_rt;
      bus_d    = in_bus;
    end

    if (flush) begin
      ds_valid_d = 1'b0;
    end else if (in_allowin) begin
      ds_valid_d = in_valid;
    end

    if (ds_valid_q && !ready_go && !flush && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // Pipeline register and counter state.
  always_ff @(posedge clk) begin
    if (reset) begin
      ds_valid_q  <= 1'b0;
      rs_q        <= '0;
      rt_q        <= '0;
      use_rs_q    <= 1'b0;
      use_rt_q    <= 1'b0;
      bus_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      ds_valid_q  <= ds_valid_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      use_rs_q    <= use_rs_d;
      use_rt_q    <= use_rt_d;
      bus_q       <= bus_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_id_operand_stage.sv
// Self-checking bench for id_operand_stage: directed scenarios plus a random
// run compared against a transaction-level model of the stage.
module tb_id_operand_stage;
  import id_operand_stage_pkg::*;

  localparam int DW = 32, RA_W = 5, NF = 3, IN_W = 64, CNT_W = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk, reset;
  logic              in_valid, in_allowin;
  logic [IN_W-1:0]   in_bus;
  logic [RA_W-1:0]   in_rs, in_rt;
  logic              in_use_rs, in_use_rt, flush;
  logic              out_valid, out_allowin;
  logic [IN_W-1:0]   out_bus;
  logic [DW-1:0]     out_rs_val, out_rt_val;
  logic [RA_W-1:0]   rf_raddr1, rf_raddr2;
  logic [DW-1:0]     rf_rdata1, rf_rdata2;
  logic [NF-1:0]     fwd_valid, fwd_ready;
  logic [NF*RA_W-1:0] fwd_dest;
  logic [NF*DW-1:0]  fwd_data;
  logic [CNT_W-1:0]  stall_cnt;

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] rf_mem [32];
  assign rf_rdata1 = rf_mem[rf_raddr1];
  assign rf_rdata2 = rf_mem[rf_raddr2];

  // Model of the held instruction
  bit            m_valid, m_urs, m_urt;
  logic [RA_W-1:0] m_rs, m_rt;
  logic [IN_W-1:0] m_bus;
  int            m_cnt;

  id_operand_stage #(.DW(DW), .RA_W(RA_W), .NUM_FWD(NF), .IN_W(IN_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_allowin(in_allowin),
    .in_bus(in_bus), .in_rs(in_rs), .in_rt(in_rt), .in_use_rs(in_use_rs),
    .in_use_rt(in_use_rt), .flush(flush), .out_valid(out_valid),
    .out_allowin(out_allowin), .out_bus(out_bus), .out_rs_val(out_rs_val),
    .out_rt_val(out_rt_val), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .fwd_valid(fwd_valid),
    .fwd_dest(fwd_dest), .fwd_ready(fwd_ready), .fwd_data(fwd_data),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Operand value: the youngest producer of r overrides everything older,
  // so walking oldest-to-youngest and overwriting leaves the youngest.
  function automatic void exp_opnd(input logic [RA_W-1:0] r, input bit u,
                                   output logic [DW-1:0] val, output bit blk);
    val = rf_mem[r];
    blk = 0;
    for (int i = NF - 1; i >= 0; i--) begin
      if (u && r != 0 && fwd_valid[i] && fwd_dest[i*RA_W +: RA_W] == r) begin
        val = fwd_data[i*DW +: DW];
        blk = !fwd_ready[i];
      end
    end
  endfunction

  task automatic model_exp(output bit ev, output bit ea, output bit go,
                           output logic [DW-1:0] vs, output logic [DW-1:0] vt);
    bit bs, bt;
    exp_opnd(m_rs, m_urs, vs, bs);
    exp_opnd(m_rt, m_urt, vt, bt);
    go = !bs && !bt;
    ev = m_valid && go && !flush;
    ea = !m_valid || (go && out_allowin);
  endtask

  // Advance one clock and update the model from the inputs of the ending cycle.
  task automatic tick();
    bit ev, ea, go, stalled, acc, fl, iv, rst;
    logic [DW-1:0] vs, vt;
    logic [RA_W-1:0] nrs, nrt;
    bit nurs, nurt;
    logic [IN_W-1:0] nbus;
    model_exp(ev, ea, go, vs, vt);
    stalled = m_valid && !go && !flush;
    acc = in_valid && ea;
    fl = flush; iv = in_valid; rst = reset;
    nrs = in_rs; nrt = in_rt; nurs = in_use_rs; nurt = in_use_rt; nbus = in_bus;
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_rs = 0; m_rt = 0; m_urs = 0; m_urt = 0; m_bus = 0; m_cnt = 0;
    end else begin
      if (stalled && m_cnt < CNT_MAX) m_cnt++;
      if (acc) begin
        m_rs = nrs; m_rt = nrt; m_urs = nurs; m_urt = nurt; m_bus = nbus;
      end
      if (fl) m_valid = 0;
      else if (ea) m_valid = iv;
    end
    #1;
  endtask

  task automatic clr_fwd();
    fwd_valid = '0; fwd_ready = '0; fwd_dest = '0; fwd_data = '0;
  endtask

  task automatic set_src(input int i, input logic [RA_W-1:0] d, input bit r,
                         input logic [DW-1:0] dat);
    fwd_valid[i] = 1'b1;
    fwd_ready[i] = r;
    fwd_dest[i*RA_W +: RA_W] = d;
    fwd_data[i*DW +: DW] = dat;
  endtask

  task automatic drive(input bit v, input logic [RA_W-1:0] rs, input logic [RA_W-1:0] rt,
                       input bit urs, input bit urt, output logic [IN_W-1:0] bus);
    bus = {$urandom(), $urandom()};
    in_valid = v; in_rs = rs; in_rt = rt; in_use_rs = urs; in_use_rt = urt; in_bus = bus;
  endtask

  task automatic do_reset();
    reset = 1; in_valid = 0; flush = 0; out_allowin = 1;
    clr_fwd();
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    logic [IN_W-1:0] b;
    reset = 1; flush = 0; out_allowin = 1;
    drive(1, 5'd3, 5'd4, 1, 1, b);
    tick(); tick();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_vec++; if (in_allowin !== 1'b1) begin n_err++; $display("FAIL rst_in_allowin: got %b want 1", in_allowin); end
    n_vec++; if (stall_cnt !== '0) begin n_err++; $display("FAIL rst_stall_cnt: got %0d want 0", stall_cnt); end
    n_vec++; if (out_bus !== '0 || rf_raddr1 !== '0 || rf_raddr2 !== '0) begin
      n_err++; $display("FAIL rst_regs: bus %h ra1 %0d ra2 %0d want all 0", out_bus, rf_raddr1, rf_raddr2);
    end
    reset = 0; in_valid = 0;
    $display("test_reset done");
  endtask

  task automatic test_no_hazard();
    logic [IN_W-1:0] bus [4];
    logic [RA_W-1:0] rs [4];
    logic [RA_W-1:0] rt [4];
    logic [IN_W-1:0] b;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        rs[i] = RA_W'($urandom_range(1, 31));
        rt[i] = RA_W'($urandom_range(1, 31));
        drive(1, rs[i], rt[i], 1, 1, b);
        bus[i] = b;
      end else begin
        in_valid = 0;
      end
      #1;
      if (i > 0) begin
        n_vec++;
        if (out_valid !== 1'b1 || in_allowin !== 1'b1 || out_rs_val !== rf_mem[rs[i-1]] ||
            out_rt_val !== rf_mem[rt[i-1]] || out_bus !== bus[i-1]) begin
          n_err++;
          $display("FAIL nohaz_%0d: got v%b a%b rs %h rt %h bus %h want v1 a1 rs %h rt %h bus %h",
                   i - 1, out_valid, in_allowin, out_rs_val, out_rt_val, out_bus,
                   rf_mem[rs[i-1]], rf_mem[rt[i-1]], bus[i-1]);
        end
        $display("issue addu %0d rs=%0d rt=%0d", i - 1, rs[i-1], rt[i-1]);
      end
      tick();
    end
    n_vec++; if (stall_cnt !== '0 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL nohaz_end: got cnt %0d valid %b want 0 0", stall_cnt, out_valid);
    end
  endtask

  task automatic test_priority();
    logic [IN_W-1:0] b;
    do_reset();
    drive(1, 5'd5, 5'd0, 1, 0, b);
    tick();
    in_valid = 0; out_allowin = 0;
    set_src(int'(FWD_EX), 5'd5, 1, 32'h11);
    set_src(int'(FWD_WB), 5'd5, 1, 32'h33);
    #1;
    n_vec++; if (out_rs_val !== 32'h11 || out_valid !== 1'b1) begin
      n_err++; $display("FAIL prio_src0: got %h v%b want 11 v1", out_rs_val, out_valid);
    end
    fwd_valid[int'(FWD_EX)] = 1'b0;
    #1;
    n_vec++; if (out_rs_val !== 32'h33) begin
      n_err++; $display("FAIL prio_src2: got %h want 33", out_rs_val);
    end
    fwd_valid[int'(FWD_EX)] = 1'b1; fwd_ready[int'(FWD_EX)] = 1'b0;
    #1;
    n_vec++; if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL prio_noolder: got valid %b want 0", out_valid);
    end
    $display("priority transaction rs=5 checked");
    out_allowin = 1; clr_fwd();
    tick();
  endtask

  task automatic test_load_use();
    logic [IN_W-1:0] ba, bb;
    do_reset();
    drive(1, 5'd3, 5'd7, 1, 1, ba);
    tick();
    set_src(int'(FWD_EX), 5'd7, 0, 32'hDEAD);
    drive(1, 5'd1, 5'd2, 1, 1, bb);
    for (int c = 0; c < 2; c++) begin
      #1;
      n_vec++; if (out_valid !== 1'b0 || in_allowin !== 1'b0 || stall_cnt !== CNT_W'(c)) begin
        n_err++; $display("FAIL lu_stall_%0d: got v%b a%b cnt %0d want v0 a0 cnt %0d",
                          c, out_valid, in_allowin, stall_cnt, c);
      end
      tick();
    end
    fwd_ready[0] = 1'b1; fwd_data[0 +: DW] = 32'hCAFE;
    #1;
    n_vec++; if (out_valid !== 1'b1 || out_rt_val !== 32'hCAFE || out_rs_val !== rf_mem[3] ||
                 stall_cnt !== CNT_W'(2) || in_allowin !== 1'b1) begin
      n_err++; $display("FAIL lu_issue: got v%b rt %h rs %h cnt %0d a%b want v1 rt cafe rs %h cnt 2 a1",
                        out_valid, out_rt_val, out_rs_val, stall_cnt, in_allowin, rf_mem[3]);
    end
    $display("issue load-use consumer rt=7");
    tick();
    clr_fwd(); in_valid = 0;
    #1;
    n_vec++; if (out_valid !== 1'b1 || out_bus !== bb) begin
      n_err++; $display("FAIL lu_next: got v%b bus %h want v1 bus %h", out_valid, out_bus, bb);
    end
    tick();
  endtask

  task automatic test_zero_unused();
    logic [IN_W-1:0] b;
    do_reset();
    set_src(0, 5'd0, 0, 32'h5555);
    set_src(1, 5'd9, 0, 32'h9999);
    drive(1, 5'd0, 5'd9, 1, 0, b);
    tick();
    in_valid = 0;
    #1;
    n_vec++; if (out_valid !== 1'b1 || out_rs_val !== 32'h0 || out_rt_val !== rf_mem[9] ||
                 stall_cnt !== '0) begin
      n_err++; $display("FAIL zero_unused: got v%b rs %h rt %h cnt %0d want v1 rs 0 rt %h cnt 0",
                        out_valid, out_rs_val, out_rt_val, stall_cnt, rf_mem[9]);
    end
    $display("issue rs=0 / unused rt");
    tick();
    clr_fwd();
  endtask

  task automatic test_flush();
    logic [IN_W-1:0] b, bc;
    do_reset();
    set_src(0, 5'd7, 0, 32'h7777);
    drive(1, 5'd0, 5'd7, 0, 1, b);
    tick();
    drive(1, 5'd2, 5'd0, 1, 0, bc);
    flush = 1;
    #1;
    n_vec++; if (out_valid !== 1'b0 || in_allowin !== 1'b0) begin
      n_err++; $display("FAIL flush_cycle: got v%b a%b want v0 a0", out_valid, in_allowin);
    end
    tick();
    flush = 0;
    #1;
    n_vec++; if (in_allowin !== 1'b1 || out_valid !== 1'b0 || stall_cnt !== '0) begin
      n_err++; $display("FAIL flush_after: got a%b v%b cnt %0d want a1 v0 cnt 0",
                        in_allowin, out_valid, stall_cnt);
    end
    tick();
    in_valid = 0;
    #1;
    n_vec++; if (out_valid !== 1'b1 || out_bus !== bc) begin
      n_err++; $display("FAIL flush_new: got v%b bus %h want v1 bus %h", out_valid, out_bus, bc);
    end
    tick();
    drive(1, 5'd1, 5'd1, 1, 1, b);
    flush = 1;
    tick();
    flush = 0; in_valid = 0;
    #1;
    n_vec++; if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL flush_drop_in: got v%b want 0", out_valid);
    end
    $display("flush transactions done");
    clr_fwd();
  endtask

  task automatic test_backpressure_sat();
    logic [IN_W-1:0] bh, be;
    int ec;
    do_reset();
    set_src(1, 5'd4, 0, 32'h44);
    drive(1, 5'd4, 5'd0, 1, 0, bh);
    tick();
    drive(1, 5'd4, 5'd0, 1, 0, be);
    for (int c = 0; c < 5; c++) begin
      #1;
      ec = (c < CNT_MAX) ? c : CNT_MAX;
      n_vec++; if (stall_cnt !== CNT_W'(ec)) begin
        n_err++; $display("FAIL sat_%0d: got cnt %0d want %0d", c, stall_cnt, ec);
      end
      tick();
    end
    fwd_ready[1] = 1'b1; out_allowin = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_vec++; if (out_valid !== 1'b1 || in_allowin !== 1'b0 || out_bus !== bh ||
                   out_rs_val !== 32'h44 || stall_cnt !== CNT_W'(CNT_MAX)) begin
        n_err++; $display("FAIL bp_%0d: got v%b a%b bus %h rs %h cnt %0d want v1 a0 bus %h rs 44 cnt %0d",
                          c, out_valid, in_allowin, out_bus, out_rs_val, stall_cnt, bh, CNT_MAX);
      end
      tick();
    end
    out_allowin = 1;
    #1;
    n_vec++; if (in_allowin !== 1'b1) begin
      n_err++; $display("FAIL bp_release: got a%b want 1", in_allowin);
    end
    tick();
    fwd_ready[1] = 1'b0; in_valid = 0;
    tick(); tick();
    reset = 1;
    tick();
    reset = 0; clr_fwd();
    #1;
    n_vec++; if (out_valid !== 1'b0 || stall_cnt !== '0 || out_bus !== '0 || out_rs_val !== '0 ||
                 out_rt_val !== '0 || rf_raddr1 !== '0 || in_allowin !== 1'b1) begin
      n_err++; $display("FAIL midstall_reset: got v%b cnt %0d bus %h rs %h rt %h ra1 %0d a%b want zeros a1",
                        out_valid, stall_cnt, out_bus, out_rs_val, out_rt_val, rf_raddr1, in_allowin);
    end
    $display("backpressure/saturation done");
  endtask

  task automatic test_random();
    bit ev, ea, go;
    logic [DW-1:0] vs, vt;
    logic [IN_W-1:0] b;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      drive(bit'($urandom_range(0, 3) != 0), RA_W'($urandom_range(0, 3)),
            RA_W'($urandom_range(0, 3)), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), b);
      for (int i = 0; i < NF; i++) begin
        fwd_valid[i] = bit'($urandom_range(0, 1));
        fwd_ready[i] = ($urandom_range(0, 3) != 0);
        fwd_dest[i*RA_W +: RA_W] = RA_W'($urandom_range(0, 3));
        fwd_data[i*DW +: DW] = $urandom();
      end
      out_allowin = ($urandom_range(0, 4) != 0);
      flush = ($urandom_range(0, 9) == 0);
      #1;
      model_exp(ev, ea, go, vs, vt);
      n_vec++; if (out_valid !== ev || in_allowin !== ea || stall_cnt !== CNT_W'(m_cnt)) begin
        n_err++; $display("FAIL rand_ctl_%0d: got v%b a%b cnt %0d want v%b a%b cnt %0d",
                          n, out_valid, in_allowin, stall_cnt, ev, ea, m_cnt);
      end
      if (ev) begin
        n_vec++; if (out_rs_val !== vs || out_rt_val !== vt || out_bus !== m_bus) begin
          n_err++; $display("FAIL rand_data_%0d: got rs %h rt %h bus %h want rs %h rt %h bus %h",
                            n, out_rs_val, out_rt_val, out_bus, vs, vt, m_bus);
        end
        $display("rand issue %0d rs=%0d rt=%0d", n, m_rs, m_rt);
      end
      tick();
    end
    flush = 0; in_valid = 0;
  endtask

  initial begin
    rf_mem[0] = '0;
    for (int i = 1; i < 32; i++) rf_mem[i] = $urandom();
    reset = 1; in_valid = 0; flush = 0; out_allowin = 1;
    in_bus = '0; in_rs = '0; in_rt = '0; in_use_rs = 0; in_use_rt = 0;
    clr_fwd();
    m_valid = 0; m_urs = 0; m_urt = 0; m_rs = '0; m_rt = '0; m_bus = '0; m_cnt = 0;
    #1;
    test_reset();
    test_no_hazard();
    test_priority();
    test_load_use();
    test_zero_unused();
    test_flush();
    test_backpressure_sat();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
